// File: rtl/flash_read_arbiter.sv
// Purpose: round-robin arbiter giving two requesters one-at-a-time access to the flash read port.
// Latency: the grant edge is followed by 3 cycles minimum to done; one IDLE cycle separates transactions.
// Backpressure: waitrequest holds ISSUE; a watchdog aborts after TIMEOUT cycles with data=0 + timeout_err.
// Ports:
//   CLK_50M, reset (async, active-high)
//   req0/req1, addr0/addr1                   requester side (level request, address sampled at grant)
//   done0/done1, data0/data1                 one-cycle done pulse and a held read word per requester
//   busy, grant, timeout_err                 status: any transaction, current owner, watchdog abort
//   flash_mem_*                              Avalon-MM read master toward flash_inst
module flash_read_arbiter #(
  parameter int ADDR_W  = 23,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK_50M,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] data0,
  output logic [DATA_W-1:0] data1,
  output logic              busy,
  output logic              grant,
  output logic              timeout_err,
  output logic              flash_mem_read,
  output logic [ADDR_W-1:0] flash_mem_address,
  output logic [3:0]        flash_mem_byteenable,
  input  logic              flash_mem_waitrequest,
  input  logic              flash_mem_readdatavalid,
  input  logic [DATA_W-1:0] flash_mem_readdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESPOND} state_t;

  state_t            state, state_nxt;
  logic              grant_r;
  logic              last_grant;
  logic              pick;
  logic              timed_out;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              hit;
  logic              capture;
  logic              abort;

  // Round-robin pick: on a tie the requester that did not go last wins.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_grant;
  end

  // Saturating watchdog count; hit means this edge would bring it to TIMEOUT.
  always_comb begin
    cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    hit     = (cnt_inc == CNT_MAX);
  end

  // Data arriving on the final allowed cycle is taken rather than aborted.
  assign capture = (state == WAIT_DATA) && flash_mem_readdatavalid;
  assign abort   = hit && ((state == ISSUE) ||
                           ((state == WAIT_DATA) && !flash_mem_readdatavalid));

  // State register
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (req0 || req1) state_nxt = ISSUE;
      ISSUE:     if (hit) state_nxt = RESPOND;
                 else if (!flash_mem_waitrequest) state_nxt = WAIT_DATA;
      WAIT_DATA: if (capture || hit) state_nxt = RESPOND;
      RESPOND:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Transaction datapath: owner, address, watchdog, result words.
  always_ff @(posedge CLK_50M or posedge reset) begin
    if (reset) begin
      grant_r    <= 1'b0;
      last_grant <= 1'b1;
      addr_r     <= '0;
      cnt        <= '0;
      timed_out  <= 1'b0;
      data0      <= '0;
      data1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant_r   <= pick;
            addr_r    <= pick ? addr1 : addr0;
            cnt       <= '0;
            timed_out <= 1'b0;
          end
        end
        ISSUE, WAIT_DATA: begin
          cnt <= cnt_inc;
          if (capture) begin
            if (grant_r) data1 <= flash_mem_readdata;
            else         data0 <= flash_mem_readdata;
          end else if (abort) begin
            timed_out <= 1'b1;
            if (grant_r) data1 <= '0;
            else         data0 <= '0;
          end
        end
        RESPOND: last_grant <= grant_r;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state so reset drops the read strobe immediately.
  always_comb begin
    flash_mem_read = (state == ISSUE);
    busy           = (state != IDLE);
    done0          = (state == RESPOND) && !grant_r;
    done1          = (state == RESPOND) &&  grant_r;
    timeout_err    = (state == RESPOND) &&  timed_out;
  end

  assign grant                = grant_r;
  assign flash_mem_address    = addr_r;
  assign flash_mem_byteenable = 4'hF;

endmodule
